// File: rtl/beta_pkg.sv
// Shared types and constants for the beta core front end.
// Imported by the fetch unit and its prefetch queue.
package beta_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [1:0]  INSTR_ALIGN_MASK = 2'b11;
  localparam int unsigned PC_INCR          = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/beta_fetch_fifo.sv
// In-order synchronous queue of fetch entries with flush and occupancy count.
// Used for both the prefetched instruction words and the PC-of-request queue.
module beta_fetch_fifo
  import beta_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Flush drops everything, including a same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/beta_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, prefetch queue,
// redirect handling with stale-response discard, and misaligned-target halt.
module beta_fetch_unit
  import beta_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic            fetch_misaligned_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    next_state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   pcq_count;
  logic [CW:0]     credit_used;
  logic            misaligned;
  logic            req;
  logic            grant;
  logic            jump_ok;
  logic            jump_bad;
  logic            drop;
  logic            push;
  logic            pop;
  logic            flush;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pcq_full;
  logic            pcq_empty;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  fetch_entry_t    pcq_data;
  fetch_entry_t    pcq_head;
  logic            unused_pcq;

  assign credit_used = (CW+1)'(outstanding) + (CW+1)'(fifo_count);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Requests only while running, never in a redirect cycle, and only with a free credit.
  always_comb begin
    next_state = state;
    req        = 1'b0;
    jump_ok    = 1'b0;
    jump_bad   = 1'b0;
    if (state == RUN) begin
      if (jump_i) begin
        if ((jump_addr_i[1:0] & INSTR_ALIGN_MASK) != 2'b00) begin
          next_state = HALT;
          jump_bad   = 1'b1;
        end else begin
          jump_ok = 1'b1;
        end
      end else if (credit_used < (CW+1)'(FIFO_DEPTH)) begin
        req = 1'b1;
      end
    end
    if (rst_i) begin
      req = 1'b0;
    end
  end

  assign grant            = req & imem_gnt_i;
  assign outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid_i);
  assign drop             = imem_rvalid_i & (discard != '0);
  assign push             = imem_rvalid_i & (discard == '0) & (state == RUN);
  assign pop              = instr_valid_o & instr_ready_i;
  assign flush            = jump_i | (state == HALT);

  // Redirect overrides the normal PC advance and resets the stale-word budget.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc          <= BOOT_ADDR;
      outstanding <= '0;
      discard     <= '0;
      misaligned  <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      if (jump_ok) begin
        pc      <= jump_addr_i;
        discard <= outstanding_next;
      end else begin
        if (grant) begin
          pc <= pc + XLEN'(PC_INCR);
        end
        if (drop) begin
          discard <= discard - CW'(1);
        end
      end
      if (jump_bad) begin
        misaligned <= 1'b1;
      end
    end
  end

  // The PC queue tracks every granted request, stale or not, so it is never flushed.
  assign pcq_data = '{instr: '0, pc: pc};

  beta_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_pc_queue (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (grant),
    .push_data (pcq_data),
    .pop       (imem_rvalid_i),
    .flush     (1'b0),
    .head      (pcq_head),
    .count     (pcq_count),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  assign push_data = '{instr: imem_rdata_i, pc: pcq_head.pc};

  beta_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_instr_queue (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign unused_pcq = ^{pcq_count, pcq_head.instr};

  assign imem_req_o         = req;
  assign imem_addr_o        = pc;
  assign instr_o            = head.instr;
  assign pc_o               = head.pc;
  assign instr_valid_o      = ~fifo_empty & (state == RUN);
  assign fetch_misaligned_o = misaligned;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full));
  a_pcq_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(grant && pcq_full));
  a_pcq_has_entry: assert property (@(posedge clk_i) disable iff (rst_i) !(imem_rvalid_i && pcq_empty));

endmodule

// File: tb/tb_beta_fetch_unit.sv
// Directed bench for beta_fetch_unit: a memory model with configurable latency and
// grant budget, plus scoreboards for granted addresses and delivered {instr, pc}.
module tb_beta_fetch_unit;
  import beta_pkg::*;

  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        fetch_misaligned_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 1;
  int grant_limit = 0;
  int grants_done = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_addr_q[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  always #5 clk = ~clk;

  beta_fetch_unit dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .imem_req_o         (imem_req_o),
    .imem_addr_o        (imem_addr_o),
    .imem_gnt_i         (imem_gnt_i),
    .imem_rvalid_i      (imem_rvalid_i),
    .imem_rdata_i       (imem_rdata_i),
    .instr_o            (instr_o),
    .pc_o               (pc_o),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .jump_i             (jump_i),
    .jump_addr_i        (jump_addr_i),
    .fetch_misaligned_o (fetch_misaligned_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model and output monitor, one iteration per clock.
  initial begin
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      imem_rvalid_i = 1'b0;
      if (rst_i) begin
        pend.delete();
      end else if (pend.size() != 0 && pend[0].due <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = pend[0].addr ^ SALT;
        void'(pend.pop_front());
      end
      imem_gnt_i = (grants_done < grant_limit);
      @(negedge clk);
      if (!rst_i && imem_req_o && imem_gnt_i) begin
        grants_done++;
        pend.push_back('{addr: imem_addr_o, due: cyc + lat});
        if (exp_addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL grant_addr: unexpected grant at %h, none expected", imem_addr_o);
        end else begin
          check("grant_addr", imem_addr_o, exp_addr_q.pop_front());
        end
      end
      // A word presented during a redirect is squashed by the consumer.
      if (!rst_i && instr_valid_o && instr_ready_i && !jump_i) begin
        if (exp_pc_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL deliver: unexpected pc %h instr %h, none expected", pc_o, instr_o);
        end else begin
          logic [31:0] e;
          e = exp_pc_q.pop_front();
          check("deliver_pc", pc_o, e);
          check("deliver_instr", instr_o, e ^ SALT);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_misaligned", 32'(fetch_misaligned_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_pc_q.size() != 0 || exp_addr_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL %s_drain: %0d pcs and %0d addrs still pending, expected 0", name,
               exp_pc_q.size(), exp_addr_q.size());
    end
    repeat (5) step();
    exp_pc_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    rst_i         = 1'b1;
    instr_ready_i = 1'b1;
    jump_i        = 1'b0;
    jump_addr_i   = '0;

    // Streaming fetch from the boot address.
    lat         = 1;
    grant_limit = grants_done + 6;
    for (int i = 0; i < 6; i++) begin
      exp_addr_q.push_back(32'(4 * i));
      exp_pc_q.push_back(32'(4 * i));
    end
    do_reset();
    @(negedge clk);
    check("c1_valid", 32'(instr_valid_o), 32'd0);
    check("c1_req", 32'(imem_req_o), 32'd1);
    check("c1_addr", imem_addr_o, 32'h0);
    step();
    @(negedge clk);
    check("c2_valid", 32'(instr_valid_o), 32'd0);
    step();
    @(negedge clk);
    check("c3_valid", 32'(instr_valid_o), 32'd1);
    check("c3_pc", pc_o, 32'h0);
    drain("stream");

    // Consumer stall: two grants fill the queue, then requests stop.
    instr_ready_i = 1'b0;
    grant_limit   = grants_done + 3;
    exp_addr_q    = '{32'h0, 32'h4, 32'h8};
    exp_pc_q      = '{32'h0, 32'h4, 32'h8};
    do_reset();
    g0 = grants_done;
    repeat (10) step();
    @(negedge clk);
    check("stall_grants", 32'(grants_done - g0), 32'd2);
    check("stall_req", 32'(imem_req_o), 32'd0);
    check("stall_valid", 32'(instr_valid_o), 32'd1);
    check("stall_pc", pc_o, 32'h0);
    step();
    instr_ready_i = 1'b1;
    drain("stall");

    // Redirect with two requests outstanding.
    lat         = 3;
    grant_limit = grants_done + 4;
    exp_addr_q  = '{32'h0, 32'h4, 32'h100, 32'h104};
    exp_pc_q    = '{32'h100, 32'h104};
    do_reset();
    step();
    step();
    jump_i      = 1'b1;
    jump_addr_i = 32'h100;
    @(negedge clk);
    check("jump1_req", 32'(imem_req_o), 32'd0);
    step();
    jump_i = 1'b0;
    drain("jump1");

    // Redirect on a pop edge, then a second redirect the next cycle.
    lat         = 1;
    grant_limit = grants_done + 5;
    exp_addr_q  = '{32'h0, 32'h4, 32'h200, 32'h204, 32'h208};
    exp_pc_q    = '{32'h200, 32'h204, 32'h208};
    do_reset();
    step();
    step();
    jump_i      = 1'b1;
    jump_addr_i = 32'h100;
    @(negedge clk);
    check("jpop_valid", 32'(instr_valid_o), 32'd1);
    step();
    jump_addr_i = 32'h200;
    @(negedge clk);
    check("jump2_req", 32'(imem_req_o), 32'd0);
    step();
    jump_i = 1'b0;
    drain("jump2");

    // Misaligned target halts fetch until reset.
    lat         = 1;
    grant_limit = grants_done + 2;
    exp_addr_q  = '{32'h0, 32'h4};
    do_reset();
    step();
    step();
    jump_i      = 1'b1;
    jump_addr_i = 32'h102;
    step();
    jump_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_misaligned", 32'(fetch_misaligned_o), 32'd1);
      check("halt_req", 32'(imem_req_o), 32'd0);
      check("halt_valid", 32'(instr_valid_o), 32'd0);
      step();
    end
    drain("halt");
    grant_limit = grants_done + 1;
    exp_addr_q  = '{32'h0};
    exp_pc_q    = '{32'h0};
    do_reset();
    @(negedge clk);
    check("resume_misaligned", 32'(fetch_misaligned_o), 32'd0);
    check("resume_addr", imem_addr_o, 32'h0);
    drain("resume");

    // Ungranted request holds its address; then wrap past the top of memory.
    lat         = 1;
    grant_limit = grants_done;
    do_reset();
    step();
    jump_i      = 1'b1;
    jump_addr_i = 32'h7FFF_FFFC;
    step();
    jump_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_req", 32'(imem_req_o), 32'd1);
      check("hold_addr", imem_addr_o, 32'h7FFF_FFFC);
      step();
    end
    exp_addr_q  = '{32'hFFFF_FFFC, 32'h0000_0000};
    exp_pc_q    = '{32'hFFFF_FFFC, 32'h0000_0000};
    jump_i      = 1'b1;
    jump_addr_i = 32'hFFFF_FFFC;
    grant_limit = grants_done + 2;
    step();
    jump_i = 1'b0;
    drain("wrap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
